// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between fetch reads and write-back writes.
// Optional macro STARVE_GUARD_EN bounds consecutive write grants while a fetch is waiting.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          wb_req,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_wdata,
  output logic          wb_gnt,
  output logic          wb_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_WB = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic grant_if;
  logic grant_wb;
  logic ack_if;
  logic ack_wb;
  logic fetch_first;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_wb) begin
          state_next = BUSY_WB;
        end else if (grant_if) begin
          state_next = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_WB: begin
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Writes win by default so stores drain before the next fetch; the guard can hand the slot to fetch.
  always_comb begin
    grant_wb = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE) begin
      if (wb_req && !(if_req && fetch_first)) begin
        grant_wb = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  assign ack_if = (state == BUSY_IF) && mem_ack;
  assign ack_wb = (state == BUSY_WB) && mem_ack;
  assign busy   = (state != IDLE);

`ifdef STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;

  assign fetch_first = (starve_cnt == CW'(STARVE_MAX));

  // Counts write grants issued while fetch kept waiting; any idle cycle without a fetch clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_if || !if_req) begin
        starve_cnt <= '0;
      end else if (grant_wb) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end
`else
  logic starve_unused;

  assign starve_unused = |STARVE_MAX;
  assign fetch_first   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      if_gnt    <= 1'b0;
      wb_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      wb_done   <= 1'b0;
      if_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt    <= grant_if;
      wb_gnt    <= grant_wb;
      if_rvalid <= ack_if;
      wb_done   <= ack_wb;
      if (ack_if) begin
        if_rdata <= mem_rdata;
      end
      // mem_wdata is only reloaded by a write so it keeps its last value across reads.
      if (grant_wb) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wb_addr;
        mem_wdata <= wb_wdata;
      end else if (grant_if) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end else if (ack_if || ack_wb) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

endmodule
